// File: rtl/instruction_fetch.sv
// Fetch stage: credit-limited request issue, an in-order pending-PC tracker and a
// 2-entry {pc, instr} output FIFO; a flush drops every response still in flight.
module instruction_fetch #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_WIDTH-1:0]  pc_in,
   output logic                   pc_en,
   input  logic                   flush,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic                   imem_resp_valid,
   input  logic [INSTR_WIDTH-1:0] imem_resp_data,
   output logic                   if_valid,
   input  logic                   if_ready,
   output logic [ADDR_WIDTH-1:0]  if_pc,
   output logic [INSTR_WIDTH-1:0] if_instr
);

   logic [1:0]             r_outstanding;
   logic [1:0]             r_fifo_cnt;
   logic [1:0]             r_discard;
   logic                   r_pq_rd;
   logic                   r_pq_wr;
   logic                   r_fifo_rd;
   logic                   r_fifo_wr;
   logic                   r_rst_q;
   logic [ADDR_WIDTH-1:0]  r_pq_pc      [2];
   logic [ADDR_WIDTH-1:0]  r_fifo_pc    [2];
   logic [INSTR_WIDTH-1:0] r_fifo_instr [2];

   logic [2:0] w_used;
   logic       w_accept;
   logic       w_resp;
   logic       w_keep;
   logic       w_pop;
   logic [1:0] w_outstanding_nxt;
   logic [1:0] w_fifo_cnt_nxt;
   logic [1:0] w_discard_nxt;

   // Requests stay blocked for one cycle after reset so credit is judged from cleared counters.
   assign w_used         = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
   assign imem_req_valid = !reset && !flush && !r_rst_q && (w_used < 3'd2);
   assign imem_addr      = pc_in;
   assign pc_en          = imem_req_valid && imem_req_ready;
   assign w_accept       = pc_en;

   assign w_resp   = imem_resp_valid && !reset && (r_outstanding != 2'd0);
   assign w_keep   = w_resp && (r_discard == 2'd0) && !flush;
   assign if_valid = !reset && (r_fifo_cnt != 2'd0);
   assign if_pc    = r_fifo_pc[r_fifo_rd];
   assign if_instr = r_fifo_instr[r_fifo_rd];
   assign w_pop    = if_valid && if_ready && !flush;

   always_comb begin
      // NOTE: each signal assigned here gets a default first, so no path can infer a latch.
      w_outstanding_nxt = r_outstanding + {1'b0, w_accept} - {1'b0, w_resp};
      w_fifo_cnt_nxt    = r_fifo_cnt + {1'b0, w_keep} - {1'b0, w_pop};
      w_discard_nxt     = r_discard;
      if (flush) begin
         w_fifo_cnt_nxt = 2'd0;
         w_discard_nxt  = r_outstanding - {1'b0, w_resp};
      end else if (w_resp && (r_discard != 2'd0)) begin
         w_discard_nxt = r_discard - 2'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      r_rst_q <= reset;
      if (reset) begin
         r_outstanding <= 2'd0;
         r_fifo_cnt    <= 2'd0;
         r_discard     <= 2'd0;
         r_pq_rd       <= 1'b0;
         r_pq_wr       <= 1'b0;
         r_fifo_rd     <= 1'b0;
         r_fifo_wr     <= 1'b0;
      end else begin
         r_outstanding <= w_outstanding_nxt;
         r_fifo_cnt    <= w_fifo_cnt_nxt;
         r_discard     <= w_discard_nxt;
         if (w_accept) r_pq_wr <= !r_pq_wr;
         if (w_resp)   r_pq_rd <= !r_pq_rd;
         if (flush) begin
            r_fifo_rd <= 1'b0;
            r_fifo_wr <= 1'b0;
         end else begin
            if (w_keep) r_fifo_wr <= !r_fifo_wr;
            if (w_pop)  r_fifo_rd <= !r_fifo_rd;
         end
      end
   end

   // NOTE: storage arrays are not reset; the counters and pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (w_accept) r_pq_pc[r_pq_wr] <= pc_in;
      if (w_keep) begin
         r_fifo_pc[r_fifo_wr]    <= r_pq_pc[r_pq_rd];
         r_fifo_instr[r_fifo_wr] <= imem_resp_data;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: an in-order memory model plus a queue-level reference of
// which fetched PCs decode must see, checked every cycle and in directed scenarios.
module tb_instruction_fetch;

   logic        clk;
   logic        reset;
   logic [31:0] pc_in;
   logic        pc_en;
   logic        flush;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   instruction_fetch #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .pc_in(pc_in), .pc_en(pc_en), .flush(flush),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Environment and reference state: program counter, memory in-flight queue, decode-visible queue.
   logic [31:0] pc = 32'h0;
   logic [31:0] addr_q [$];
   int          due_q  [$];
   bit          stale_q[$];
   logic [31:0] exp_q  [$];
   int          cyc = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          blank = 1'b0;

   function automatic logic [31:0] mk_instr(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic do_reset(input int n, input bit junk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset           = 1'b1;
         flush           = 1'b0;
         if_ready        = 1'($urandom);
         imem_req_ready  = 1'($urandom);
         pc_in           = pc;
         imem_resp_valid = junk;
         imem_resp_data  = $urandom;
         #1;
         total++;
         if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_en !== 1'b0) begin
            bad++;
            $display("FAIL in_reset got if_valid=%b req_valid=%b pc_en=%b exp 0 0 0",
                     if_valid, imem_req_valid, pc_en);
         end
         @(posedge clk);
         cyc++;
      end
      addr_q.delete(); due_q.delete(); stale_q.delete(); exp_q.delete();
      blank = 1'b1;
   endtask

   // One clock cycle: drive inputs, compare outputs against the reference, then advance it.
   task automatic step(input bit fl, input logic [31:0] tgt, input bit rdy, input bit mrdy,
                       input bit men, input bit junk,
                       output logic o_pcen, output logic [31:0] o_addr, output logic o_ifvalid,
                       output bit o_take, output logic [31:0] o_take_pc);
      bit          resp;
      bit          exp_rv;
      bit          acc;
      logic [31:0] ra;
      @(negedge clk);
      reset          = 1'b0;
      flush          = fl;
      if_ready       = rdy;
      imem_req_ready = mrdy;
      pc_in          = pc;
      resp           = men && (addr_q.size() > 0) && (due_q.size() > 0) && (due_q[0] <= cyc);
      imem_resp_valid = resp || (junk && addr_q.size() == 0);
      imem_resp_data  = resp ? mk_instr(addr_q[0]) : $urandom;
      exp_rv = !fl && !blank && ((addr_q.size() + exp_q.size()) < 2);
      #1;
      o_pcen    = pc_en;
      o_addr    = imem_addr;
      o_ifvalid = if_valid;
      o_take    = (if_valid === 1'b1) && rdy;
      o_take_pc = if_pc;
      total++;
      if (if_valid !== (exp_q.size() > 0)) begin
         bad++;
         $display("FAIL if_valid cyc=%0d got=%b exp=%b", cyc, if_valid, exp_q.size() > 0);
      end
      if (exp_q.size() > 0) begin
         total++;
         if (if_pc !== exp_q[0] || if_instr !== mk_instr(exp_q[0])) begin
            bad++;
            $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                     cyc, if_pc, if_instr, exp_q[0], mk_instr(exp_q[0]));
         end
      end
      total++;
      if (imem_req_valid !== exp_rv || pc_en !== (exp_rv && mrdy)) begin
         bad++;
         $display("FAIL request cyc=%0d got req_valid=%b pc_en=%b exp %b %b",
                  cyc, imem_req_valid, pc_en, exp_rv, exp_rv && mrdy);
      end
      total++;
      if (imem_addr !== pc) begin
         bad++;
         $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, pc);
      end
      @(posedge clk);
      acc = exp_rv && mrdy;
      if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
      if (resp) begin
         ra = addr_q.pop_front();
         void'(due_q.pop_front());
         if (!stale_q.pop_front() && !fl) exp_q.push_back(ra);
      end
      if (fl) begin
         exp_q.delete();
         foreach (stale_q[i]) stale_q[i] = 1'b1;
         pc = tgt;
      end
      if (acc) begin
         addr_q.push_back(pc);
         due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
         stale_q.push_back(1'b0);
         pc = pc + 32'd4;
      end
      blank = 1'b0;
      cyc++;
   endtask

   task automatic test_reset();
      logic pe, iv;
      logic [31:0] ad, tp;
      bit tk;
      lat_min = 1; lat_max = 1; pc = 32'h0;
      do_reset(3, 1'b0);
      step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
      total++;
      if (pe !== 1'b0 || iv !== 1'b0) begin
         bad++;
         $display("FAIL reset_blank got pc_en=%b if_valid=%b exp 0 0", pe, iv);
      end
      step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
      total++;
      if (pe !== 1'b1 || ad !== 32'h0) begin
         bad++;
         $display("FAIL first_req got pc_en=%b addr=%h exp 1 00000000", pe, ad);
      end
   endtask

   task automatic test_streaming();
      logic pe, iv;
      logic [31:0] ad, tp;
      bit tk;
      logic [31:0] want = 32'h0;
      int takes = 0;
      lat_min = 1; lat_max = 1; pc = 32'h0;
      do_reset(2, 1'b0);
      for (int i = 0; i < 24; i++) begin
         step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
         if (tk) begin
            takes++;
            total++;
            if (tp !== want) begin
               bad++;
               $display("FAIL stream_order got=%h exp=%h", tp, want);
            end
            want = want + 32'd4;
         end
      end
      total++;
      if (takes < 10) begin
         bad++;
         $display("FAIL stream_count got=%0d exp>=10", takes);
      end
   endtask

   task automatic test_stall();
      logic pe, iv;
      logic [31:0] ad, tp;
      bit tk;
      logic [31:0] want = 32'h0;
      lat_min = 1; lat_max = 1; pc = 32'h0;
      do_reset(2, 1'b0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0, pe, ad, iv, tk, tp);
      #1;
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_req_valid !== 1'b0 || pc_en !== 1'b0) begin
         bad++;
         $display("FAIL stall_hold got valid=%b pc=%h req=%b pc_en=%b exp 1 00000000 0 0",
                  if_valid, if_pc, imem_req_valid, pc_en);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
         if (tk && want < 32'h8) begin
            total++;
            if (tp !== want) begin
               bad++;
               $display("FAIL stall_release got=%h exp=%h", tp, want);
            end
            want = want + 32'd4;
         end
      end
      total++;
      if (want !== 32'h8) begin
         bad++;
         $display("FAIL stall_drain got next=%h exp=00000008", want);
      end
   endtask

   task automatic test_backpressure();
      logic pe, iv;
      logic [31:0] ad, tp;
      bit tk;
      lat_min = 1; lat_max = 1; pc = 32'h0;
      do_reset(2, 1'b0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0, 1, 0, pe, ad, iv, tk, tp);
         total++;
         if (pe !== 1'b0 || ad !== 32'h8) begin
            bad++;
            $display("FAIL bp_hold got pc_en=%b addr=%h exp 0 00000008", pe, ad);
         end
      end
      step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
      total++;
      if (pe !== 1'b1 || ad !== 32'h8) begin
         bad++;
         $display("FAIL bp_release got pc_en=%b addr=%h exp 1 00000008", pe, ad);
      end
   endtask

   task automatic test_flush_two();
      logic pe, iv;
      logic [31:0] ad, tp;
      bit tk;
      bit seen_take = 1'b0;
      bit seen_req  = 1'b0;
      lat_min = 3; lat_max = 3; pc = 32'h0;
      do_reset(2, 1'b0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
      step(1, 32'hCAFE_BABC, 1, 1, 1, 0, pe, ad, iv, tk, tp);
      for (int i = 0; i < 14; i++) begin
         step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
         if (pe === 1'b1 && !seen_req) begin
            seen_req = 1'b1;
            total++;
            if (ad !== 32'hCAFE_BABC) begin
               bad++;
               $display("FAIL flush_first_req got=%h exp=cafebabc", ad);
            end
         end
         if (tk && !seen_take) begin
            seen_take = 1'b1;
            total++;
            if (tp !== 32'hCAFE_BABC) begin
               bad++;
               $display("FAIL flush_first_pc got=%h exp=cafebabc", tp);
            end
         end
      end
      total++;
      if (!seen_take) begin
         bad++;
         $display("FAIL flush_timeout got no instruction exp cafebabc within 14 cycles");
      end
   endtask

   task automatic test_flush_resp();
      logic pe, iv;
      logic [31:0] ad, tp;
      bit tk;
      bit seen_take = 1'b0;
      lat_min = 1; lat_max = 1; pc = 32'h0;
      do_reset(2, 1'b0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0, pe, ad, iv, tk, tp);
      step(1, 32'h0000_2000, 0, 1, 1, 0, pe, ad, iv, tk, tp);
      step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
      total++;
      if (iv !== 1'b0) begin
         bad++;
         $display("FAIL flush_resp_valid got=%b exp=0", iv);
      end
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
         if (tk && !seen_take) begin
            seen_take = 1'b1;
            total++;
            if (tp !== 32'h0000_2000) begin
               bad++;
               $display("FAIL flush_resp_pc got=%h exp=00002000", tp);
            end
         end
      end
      total++;
      if (!seen_take) begin
         bad++;
         $display("FAIL flush_resp_timeout got no instruction exp 00002000 within 8 cycles");
      end
   endtask

   task automatic test_reset_mid();
      logic pe, iv;
      logic [31:0] ad, tp;
      bit tk;
      bit seen_take = 1'b0;
      lat_min = 2; lat_max = 2; pc = 32'h0;
      do_reset(2, 1'b0);
      step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
      step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
      step(0, 0, 1, 0, 1, 0, pe, ad, iv, tk, tp);
      pc = 32'h0000_0100;
      do_reset(2, 1'b1);
      step(0, 0, 1, 1, 1, 1, pe, ad, iv, tk, tp);
      total++;
      if (iv !== 1'b0 || pe !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_blank got if_valid=%b pc_en=%b exp 0 0", iv, pe);
      end
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
         if (tk && !seen_take) begin
            seen_take = 1'b1;
            total++;
            if (tp !== 32'h0000_0100) begin
               bad++;
               $display("FAIL reset_mid_pc got=%h exp=00000100", tp);
            end
         end
      end
      total++;
      if (!seen_take) begin
         bad++;
         $display("FAIL reset_mid_timeout got no instruction exp 00000100 within 8 cycles");
      end
   endtask

   task automatic test_random();
      logic pe, iv;
      logic [31:0] ad, tp;
      bit tk;
      int takes = 0;
      lat_min = 1; lat_max = 4; pc = {$urandom_range(255, 0), 2'b00};
      do_reset(2, 1'b0);
      step(0, 0, 1, 1, 1, 0, pe, ad, iv, tk, tp);
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(19, 0) == 0), {$urandom, 2'b00} >> 2 << 2,
              ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0),
              ($urandom_range(3, 0) != 0), 1'($urandom), pe, ad, iv, tk, tp);
         if (tk) takes++;
      end
      total++;
      if (takes < 100) begin
         bad++;
         $display("FAIL random_progress got=%0d exp>=100", takes);
      end
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; pc_in = 32'h0; if_ready = 1'b0;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
      test_reset();
      test_streaming();
      test_stall();
      test_backpressure();
      test_flush_two();
      test_flush_resp();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
